// File: rtl/tvout_pkg.sv
// Shared types and per-standard vertical timing constants for the TV-out raster generator.
// Line boundaries are half-open: a line type runs from its start up to but not including the *_END line.
package tvout_pkg;

  typedef enum logic {
    MODE_PAL  = 1'b0,
    MODE_NTSC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    NORMAL,
    BROAD_BROAD,
    BROAD_EQ,
    EQ_EQ
  } line_type_e;

  localparam logic [8:0] PAL_V_LONG         = 9'd313;
  localparam logic [8:0] PAL_BROAD_END      = 9'd2;
  localparam logic [8:0] PAL_BROAD_EQ_LINE  = 9'd2;
  localparam logic [8:0] PAL_EQ_END         = 9'd5;
  localparam logic [8:0] PAL_TAIL_EQ        = 9'd309;

  localparam logic [8:0] NTSC_V_LONG        = 9'd263;
  localparam logic [8:0] NTSC_PRE_EQ_END    = 9'd3;
  localparam logic [8:0] NTSC_BROAD_END     = 9'd6;
  localparam logic [8:0] NTSC_POST_EQ_END   = 9'd9;
  localparam logic [8:0] NTSC_TAIL_EQ       = 9'd259;

  function automatic logic [8:0] v_long(input mode_e mode);
    return (mode == MODE_NTSC) ? NTSC_V_LONG : PAL_V_LONG;
  endfunction

endpackage

// File: rtl/tvout_linetype.sv
// tvout_linetype: maps (mode, line number) to the sync pattern used on that line.
// Purely combinational, zero latency; no flow control.
module tvout_linetype
  import tvout_pkg::*;
(
  input  mode_e      mode_i,
  input  logic [8:0] cnt_v_i,
  output line_type_e line_type_o
);

  always_comb begin
    line_type_o = NORMAL;
    if (mode_i == MODE_PAL) begin
      if (cnt_v_i < PAL_BROAD_END) begin
        line_type_o = BROAD_BROAD;
      end else if (cnt_v_i == PAL_BROAD_EQ_LINE) begin
        line_type_o = BROAD_EQ;
      end else if ((cnt_v_i < PAL_EQ_END) || (cnt_v_i >= PAL_TAIL_EQ)) begin
        line_type_o = EQ_EQ;
      end
    end else begin
      if (cnt_v_i < NTSC_PRE_EQ_END) begin
        line_type_o = EQ_EQ;
      end else if (cnt_v_i < NTSC_BROAD_END) begin
        line_type_o = BROAD_BROAD;
      end else if ((cnt_v_i < NTSC_POST_EQ_END) || (cnt_v_i >= NTSC_TAIL_EQ)) begin
        line_type_o = EQ_EQ;
      end
    end
  end

endmodule

// File: rtl/tvout_gen.sv
// tvout_gen: PAL/NTSC raster timing with composite sync, blanking, data-enable and field start.
// Outputs registered, one clock behind the counters; free-running source, no backpressure.
module tvout_gen
  import tvout_pkg::*;
#(
  parameter int H_TOTAL     = 512,
  parameter int H_SYNC      = 37,
  parameter int H_ACT_START = 96,
  parameter int H_ACT_LEN   = 384,
  parameter int V_ACT_START = 40,
  parameter int V_ACT_LEN   = 240,
  localparam int HW         = $clog2(H_TOTAL)
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          ntsc,
  input  logic          interlace_en,
  output logic [HW-1:0] cnt_h,
  output logic [8:0]    cnt_v,
  output logic          field,
  output logic          hsync,
  output logic          vbl,
  output logic          de,
  output logic          out_sync,
  output logic          frame_start
);

  localparam int unsigned HALF_U      = H_TOTAL / 2;
  localparam int unsigned EQ_W        = H_TOTAL / 32;
  localparam int unsigned BROAD_W     = HALF_U - EQ_W;
  localparam int unsigned H_SYNC_U    = H_SYNC;
  localparam int unsigned H_ACT_BEG_U = H_ACT_START;
  localparam int unsigned H_ACT_END_U = H_ACT_START + H_ACT_LEN;
  localparam int unsigned V_ACT_BEG_U = V_ACT_START;
  localparam int unsigned V_ACT_END_U = V_ACT_START + V_ACT_LEN;

  logic [HW-1:0] cnt_h_q, cnt_h_d;
  logic [8:0]    cnt_v_q, cnt_v_d;
  logic          field_q, field_d;
  mode_e         mode_q, mode_d;
  logic          hsync_q, vbl_q, de_q, out_sync_q, frame_start_q;

  line_type_e    line_type;
  logic [8:0]    v_last_line;
  logic          h_last, v_last;
  logic [HW-2:0] h_pos;
  logic          pulse_broad;
  logic [31:0]   pulse_w;
  logic          in_hsync, sync_tip, h_active, v_active;

  tvout_linetype u_linetype (
    .mode_i      (mode_q),
    .cnt_v_i     (cnt_v_q),
    .line_type_o (line_type)
  );

  // Short fields end one line early; field_q is 1 only during a short field.
  assign v_last_line = v_long(mode_q) - 9'd1 - {8'd0, field_q};
  assign h_last      = (cnt_h_q == HW'(H_TOTAL - 1));
  assign v_last      = (cnt_v_q == v_last_line);

  always_comb begin
    cnt_h_d = cnt_h_q + HW'(1);
    cnt_v_d = cnt_v_q;
    field_d = field_q;
    mode_d  = mode_q;
    if (h_last) begin
      cnt_h_d = '0;
      if (v_last) begin
        cnt_v_d = '0;
        field_d = interlace_en ? ~field_q : 1'b0;
        mode_d  = ntsc ? MODE_NTSC : MODE_PAL;
      end else begin
        cnt_v_d = cnt_v_q + 9'd1;
      end
    end
  end

  // Serration pulses restart at each half line, so only the low bits position them.
  always_comb begin
    h_pos = cnt_h_q[HW-2:0];
    unique case (line_type)
      BROAD_BROAD: pulse_broad = 1'b1;
      BROAD_EQ:    pulse_broad = ~cnt_h_q[HW-1];
      default:     pulse_broad = 1'b0;
    endcase
    pulse_w  = pulse_broad ? BROAD_W : EQ_W;
    in_hsync = (32'(cnt_h_q) < H_SYNC_U);
    sync_tip = (line_type == NORMAL) ? in_hsync : (32'(h_pos) < pulse_w);
    h_active = (32'(cnt_h_q) >= H_ACT_BEG_U) && (32'(cnt_h_q) < H_ACT_END_U);
    v_active = (32'(cnt_v_q) >= V_ACT_BEG_U) && (32'(cnt_v_q) < V_ACT_END_U);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      field_q       <= 1'b0;
      mode_q        <= MODE_PAL;
      hsync_q       <= 1'b0;
      out_sync_q    <= 1'b1;
      vbl_q         <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      field_q       <= field_d;
      mode_q        <= mode_d;
      hsync_q       <= in_hsync;
      out_sync_q    <= ~sync_tip;
      vbl_q         <= ~v_active;
      de_q          <= v_active & h_active;
      frame_start_q <= (cnt_h_q == '0) && (cnt_v_q == '0);
    end
  end

  assign cnt_h       = cnt_h_q;
  assign cnt_v       = cnt_v_q;
  assign field       = field_q;
  assign hsync       = hsync_q;
  assign vbl         = vbl_q;
  assign de          = de_q;
  assign out_sync    = out_sync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tvout_gen.sv
// Bench for tvout_gen with a short 32-clock line so several whole fields fit the run.
// Expected outputs are keyed on the counter value they reflect and checked one clock later.
module tb_tvout_gen;

  localparam int HT = 32;
  localparam int WAIT_MAX = 12000;

  localparam int S_OS = 0;
  localparam int S_HS = 1;
  localparam int S_VBL = 2;
  localparam int S_DE = 3;
  localparam int S_FS = 4;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic       ntsc;
  logic       interlace_en;
  logic [4:0] cnt_h;
  logic [8:0] cnt_v;
  logic       field, hsync, vbl, de, out_sync, frame_start;

  tvout_gen #(
    .H_TOTAL     (HT),
    .H_SYNC      (3),
    .H_ACT_START (6),
    .H_ACT_LEN   (24),
    .V_ACT_START (40),
    .V_ACT_LEN   (240)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .ntsc         (ntsc),
    .interlace_en (interlace_en),
    .cnt_h        (cnt_h),
    .cnt_v        (cnt_v),
    .field        (field),
    .hsync        (hsync),
    .vbl          (vbl),
    .de           (de),
    .out_sync     (out_sync),
    .frame_start  (frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct { string nm; int v; int h; int sig; int exp; } pt_t;
  typedef struct { string nm; int lines; int fld; } fl_t;

  pt_t q_pt[$];
  fl_t q_fl[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_pt(input string nm, input int v, input int h, input int sig, input int exp);
    pt_t p;
    p.nm = nm; p.v = v; p.h = h; p.sig = sig; p.exp = exp;
    q_pt.push_back(p);
  endtask

  task automatic push_fl(input string nm, input int lines, input int fld);
    fl_t f;
    f.nm = nm; f.lines = lines; f.fld = fld;
    q_fl.push_back(f);
  endtask

  // Monitor: pops point checks when the previous-cycle counters match, and
  // measures field length between frame_start pulses.
  int     pv, ph, act, fs_field;
  bit     pvalid = 1'b0;
  bit     fs_valid = 1'b0;
  longint cyc = 0;
  longint fs_cyc = 0;
  pt_t    mp;
  fl_t    mf;

  always @(negedge pixel_clk) begin
    cyc++;
    if (!rst_n) begin
      pvalid   = 1'b0;
      fs_valid = 1'b0;
    end else begin
      while (pvalid && q_pt.size() > 0 && q_pt[0].v == pv && q_pt[0].h == ph) begin
        mp = q_pt.pop_front();
        case (mp.sig)
          S_OS:    act = int'(out_sync);
          S_HS:    act = int'(hsync);
          S_VBL:   act = int'(vbl);
          S_DE:    act = int'(de);
          default: act = int'(frame_start);
        endcase
        chk($sformatf("%s v%0d h%0d", mp.nm, mp.v, mp.h), act, mp.exp);
      end
      if (frame_start) begin
        if (fs_valid && q_fl.size() > 0) begin
          mf = q_fl.pop_front();
          chk({mf.nm, " lines"}, int'((cyc - fs_cyc) / HT), mf.lines);
          chk({mf.nm, " field"}, fs_field, mf.fld);
        end
        fs_valid = 1'b1;
        fs_cyc   = cyc;
        fs_field = int'(field);
      end
      pv     = int'(cnt_v);
      ph     = int'(cnt_h);
      pvalid = 1'b1;
    end
  end

  task automatic wait_fs(input string nm);
    int k = 0;
    @(negedge pixel_clk);
    while (frame_start && k < WAIT_MAX) begin @(negedge pixel_clk); k++; end
    while (!frame_start && k < WAIT_MAX) begin @(negedge pixel_clk); k++; end
    chk(nm, int'(frame_start), 1);
  endtask

  task automatic wait_pos(input string nm, input int v, input int h);
    int k = 0;
    do begin
      @(negedge pixel_clk);
      k++;
    end while (!(cnt_v == v && cnt_h == h) && k < WAIT_MAX);
    chk(nm, int'(cnt_v == v && cnt_h == h), 1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " cnt_h"}, int'(cnt_h), 0);
    chk({nm, " cnt_v"}, int'(cnt_v), 0);
    chk({nm, " field"}, int'(field), 0);
    chk({nm, " hsync"}, int'(hsync), 0);
    chk({nm, " out_sync"}, int'(out_sync), 1);
    chk({nm, " vbl"}, int'(vbl), 1);
    chk({nm, " de"}, int'(de), 0);
    chk({nm, " frame_start"}, int'(frame_start), 0);
  endtask

  task automatic release_and_check(input string nm);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    @(posedge pixel_clk);
    #1;
    chk({nm, " cnt_h"}, int'(cnt_h), 1);
    chk({nm, " cnt_v"}, int'(cnt_v), 0);
    chk({nm, " frame_start"}, int'(frame_start), 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    ntsc         = 1'b0;
    interlace_en = 1'b1;

    push_fl("A pal long", 313, 0);
    push_fl("B pal short", 312, 1);
    push_fl("C pal long ntsc-mid", 313, 0);
    push_fl("D ntsc long", 263, 0);
    push_fl("G after reset", 313, 0);

    // Field A (PAL): broad/EQ/normal patterns, blanking and data-enable window.
    push_pt("A1 os", 1, 0, S_OS, 0);   push_pt("A1 hs", 1, 2, S_HS, 1);
    push_pt("A1 hs", 1, 5, S_HS, 0);   push_pt("A1 os", 1, 14, S_OS, 0);
    push_pt("A1 os", 1, 15, S_OS, 1);  push_pt("A1 os", 1, 16, S_OS, 0);
    push_pt("A1 os", 1, 30, S_OS, 0);  push_pt("A1 os", 1, 31, S_OS, 1);
    push_pt("A2 os", 2, 14, S_OS, 0);  push_pt("A2 os", 2, 15, S_OS, 1);
    push_pt("A2 os", 2, 16, S_OS, 0);  push_pt("A2 os", 2, 17, S_OS, 1);
    push_pt("A3 os", 3, 0, S_OS, 0);   push_pt("A3 os", 3, 1, S_OS, 1);
    push_pt("A3 os", 3, 16, S_OS, 0);  push_pt("A3 os", 3, 17, S_OS, 1);
    push_pt("A5 os", 5, 2, S_OS, 0);   push_pt("A5 os", 5, 3, S_OS, 1);
    push_pt("A5 fs", 5, 5, S_FS, 0);   push_pt("A5 os", 5, 16, S_OS, 1);
    push_pt("A39 vbl", 39, 10, S_VBL, 1);
    push_pt("A40 os", 40, 2, S_OS, 0); push_pt("A40 os", 40, 3, S_OS, 1);
    push_pt("A40 de", 40, 5, S_DE, 0); push_pt("A40 de", 40, 6, S_DE, 1);
    push_pt("A40 vbl", 40, 10, S_VBL, 0);
    push_pt("A40 de", 40, 29, S_DE, 1); push_pt("A40 de", 40, 30, S_DE, 0);
    push_pt("A100 os", 100, 0, S_OS, 0); push_pt("A100 os", 100, 2, S_OS, 0);
    push_pt("A100 hs", 100, 2, S_HS, 1); push_pt("A100 os", 100, 3, S_OS, 1);
    push_pt("A100 hs", 100, 3, S_HS, 0); push_pt("A100 os", 100, 16, S_OS, 1);
    push_pt("A279 vbl", 279, 10, S_VBL, 0); push_pt("A279 de", 279, 10, S_DE, 1);
    push_pt("A280 vbl", 280, 10, S_VBL, 1); push_pt("A280 de", 280, 10, S_DE, 0);
    push_pt("A308 os", 308, 0, S_OS, 0); push_pt("A308 os", 308, 16, S_OS, 1);
    push_pt("A309 os", 309, 1, S_OS, 1); push_pt("A309 os", 309, 16, S_OS, 0);
    push_pt("A312 os", 312, 16, S_OS, 0);
    push_pt("B0 fs", 0, 0, S_FS, 1);   push_pt("B0 fs", 0, 1, S_FS, 0);
    push_pt("B311 os", 311, 16, S_OS, 0);
    push_pt("C0 fs", 0, 0, S_FS, 1);

    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_vals("reset");
    release_and_check("release1");

    wait_fs("B start");
    wait_fs("C start");
    wait_pos("C line10", 10, 0);
    ntsc         = 1'b1;
    interlace_en = 1'b0;

    wait_fs("D start");
    push_pt("D1 os", 1, 0, S_OS, 0);   push_pt("D1 os", 1, 1, S_OS, 1);
    push_pt("D1 os", 1, 16, S_OS, 0);  push_pt("D1 os", 1, 17, S_OS, 1);
    push_pt("D3 os", 3, 14, S_OS, 0);  push_pt("D3 os", 3, 15, S_OS, 1);
    push_pt("D3 os", 3, 30, S_OS, 0);
    push_pt("D5 os", 5, 30, S_OS, 0);  push_pt("D5 os", 5, 31, S_OS, 1);
    push_pt("D6 os", 6, 1, S_OS, 1);   push_pt("D6 os", 6, 16, S_OS, 0);
    push_pt("D9 os", 9, 2, S_OS, 0);   push_pt("D9 os", 9, 16, S_OS, 1);
    push_pt("D258 os", 258, 16, S_OS, 1);
    push_pt("D259 os", 259, 16, S_OS, 0);
    push_pt("D262 os", 262, 16, S_OS, 0);
    push_pt("E0 fs", 0, 0, S_FS, 1);
    wait_pos("D line20", 20, 0);
    ntsc = 1'b0;

    wait_fs("E start");
    chk("E field", int'(field), 0);
    wait_pos("E line150", 150, 18);
    chk("E pre-reset de", int'(de), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midline reset");
    repeat (2) @(posedge pixel_clk);
    release_and_check("release2");

    wait_fs("G end");
    repeat (2) @(negedge pixel_clk);
    chk("point queue drained", q_pt.size(), 0);
    chk("field queue drained", q_fl.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
